// File: rtl/uncached_bus_master.sv
// Uncached read master: turns an uncached-enable request into one Wishbone-style
// read cycle and returns a ready pulse with data, or an error on err/timeout.
module uncached_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] ERROR_DATA     = 32'hFFFF_FFFF
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [31:0] adr_i,
    output logic        ready_o,
    output logic [31:0] dat_o,
    output logic [31:0] bus_adr_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    output logic        error_o,
    output logic        error_sticky_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } state_e;

    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] dat_q, dat_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    logic        sticky_q, sticky_d;
    logic        timeout_hit;

    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        dat_d    = dat_q;
        sticky_d = sticky_q;
        error_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_BUS;
                    cnt_d   = '0;
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + 16'd1;
                // ack wins over err, err wins over timeout
                if (bus_ack_i) begin
                    dat_d   = bus_dat_i;
                    state_d = ST_DONE;
                end else if (bus_err_i || timeout_hit) begin
                    dat_d    = ERROR_DATA;
                    error_d  = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                // upstream still holds enable this cycle, so it is not looked at here
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock_i) begin
        // NOTE: reset is synchronous; all state including the data register is cleared so
        // an aborted access leaves no stale ready, data or error behind.
        if (reset_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dat_q    <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus_cyc_o      = (state_q == ST_BUS);
    assign bus_stb_o      = (state_q == ST_BUS);
    assign bus_adr_o      = (state_q == ST_BUS) ? adr_i : 32'h0;
    assign bus_we_o       = 1'b0;
    assign bus_sel_o      = 4'hF;
    assign ready_o        = ready_q;
    assign error_o        = error_q;
    assign dat_o          = dat_q;
    assign error_sticky_o = sticky_q;

endmodule
